// File: rtl/operand_collector_unit_if.sv
// Operand collector port bundle: allocation, bank read returns and dispatch.
// The slave modport is the collector's view; master is the driving side.
interface operand_collector_unit_if #(
    parameter int DATA_W = 256,
    parameter int TAG_W  = 32
);
    logic              alloc_valid;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              alloc_src1_valid;
    logic [1:0]        alloc_src1_bank;
    logic              alloc_src2_valid;
    logic [1:0]        alloc_src2_bank;

    logic              rd_valid_0;
    logic              rd_valid_1;
    logic              rd_valid_2;
    logic              rd_valid_3;
    logic [3:0]        rd_ocid_0;
    logic [3:0]        rd_ocid_1;
    logic [3:0]        rd_ocid_2;
    logic [3:0]        rd_ocid_3;
    logic [DATA_W-1:0] rd_data_0;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic [DATA_W-1:0] rd_data_3;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_src1_data;
    logic [DATA_W-1:0] out_src2_data;
    logic              busy;
    logic              err_unexpected;

    modport slave (
        input  alloc_valid, alloc_tag,
        input  alloc_src1_valid, alloc_src1_bank,
        input  alloc_src2_valid, alloc_src2_bank,
        input  rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
        input  rd_ocid_0, rd_ocid_1, rd_ocid_2, rd_ocid_3,
        input  rd_data_0, rd_data_1, rd_data_2, rd_data_3,
        input  out_ready,
        output alloc_ready, out_valid, out_tag,
        output out_src1_data, out_src2_data,
        output busy, err_unexpected
    );

    modport master (
        output alloc_valid, alloc_tag,
        output alloc_src1_valid, alloc_src1_bank,
        output alloc_src2_valid, alloc_src2_bank,
        output rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3,
        output rd_ocid_0, rd_ocid_1, rd_ocid_2, rd_ocid_3,
        output rd_data_0, rd_data_1, rd_data_2, rd_data_3,
        output out_ready,
        input  alloc_ready, out_valid, out_tag,
        input  out_src1_data, out_src2_data,
        input  busy, err_unexpected
    );
endinterface

// File: rtl/operand_collector_unit.sv
// One operand collector slot: snoops bank returns tagged with OC_ID,
// gathers src1/src2 and hands them to dispatch with valid/ready.
module operand_collector_unit #(
    parameter logic [3:0] OC_ID  = 4'd0,
    parameter int         DATA_W = 256,
    parameter int         TAG_W  = 32
) (
    input logic clk,
    input logic rst,
    operand_collector_unit_if.slave io
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPATCH
    } state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [1:0]        bank1_q, bank1_d;
    logic [1:0]        bank2_q, bank2_d;
    logic              pend1_q, pend1_d;
    logic              pend2_q, pend2_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic              err_q, err_d;

    logic [3:0]        hit;
    logic [DATA_W-1:0] rd_data [4];

    assign rd_data[0] = io.rd_data_0;
    assign rd_data[1] = io.rd_data_1;
    assign rd_data[2] = io.rd_data_2;
    assign rd_data[3] = io.rd_data_3;

    assign hit[0] = io.rd_valid_0 && (io.rd_ocid_0 == OC_ID);
    assign hit[1] = io.rd_valid_1 && (io.rd_ocid_1 == OC_ID);
    assign hit[2] = io.rd_valid_2 && (io.rd_ocid_2 == OC_ID);
    assign hit[3] = io.rd_valid_3 && (io.rd_ocid_3 == OC_ID);

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        bank1_d = bank1_q;
        bank2_d = bank2_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = |hit;
                if (io.alloc_valid) begin
                    tag_d   = io.alloc_tag;
                    bank1_d = io.alloc_src1_bank;
                    bank2_d = io.alloc_src2_bank;
                    pend1_d = io.alloc_src1_valid;
                    pend2_d = io.alloc_src2_valid;
                    src1_d  = '0;
                    src2_d  = '0;
                    state_d = (io.alloc_src1_valid || io.alloc_src2_valid)
                            ? COLLECT : DISPATCH;
                end
            end
            COLLECT: begin
                // One return per bank per cycle, so a same-bank pair
                // always resolves src1 first on the earlier return.
                for (int b = 0; b < 4; b++) begin
                    if (hit[b]) begin
                        if (pend1_q && bank1_q == 2'(b)) begin
                            src1_d  = rd_data[b];
                            pend1_d = 1'b0;
                        end else if (pend2_q && bank2_q == 2'(b)) begin
                            src2_d  = rd_data[b];
                            pend2_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (!pend1_d && !pend2_d) state_d = DISPATCH;
            end
            DISPATCH: begin
                err_d = |hit;
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            bank1_q <= '0;
            bank2_q <= '0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            bank1_q <= bank1_d;
            bank2_q <= bank2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            err_q   <= err_d;
        end
    end

    assign io.alloc_ready    = (state_q == IDLE);
    assign io.busy           = (state_q != IDLE);
    assign io.out_valid      = (state_q == DISPATCH);
    assign io.out_tag        = tag_q;
    assign io.out_src1_data  = src1_q;
    assign io.out_src2_data  = src2_q;
    assign io.err_unexpected = err_q;

endmodule

// File: tb/tb_operand_collector_unit.sv
// Directed and randomized checks of one operand collector slot against
// a queue-based model of outstanding operands.
module tb_operand_collector_unit;

    localparam int         DATA_W = 256;
    localparam int         TAG_W  = 32;
    localparam logic [3:0] OC_ID  = 4'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    operand_collector_unit_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    operand_collector_unit #(
        .OC_ID (OC_ID),
        .DATA_W(DATA_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
        return {(DATA_W / 8){b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_rd();
        bus.rd_valid_0 = 1'b0;
        bus.rd_valid_1 = 1'b0;
        bus.rd_valid_2 = 1'b0;
        bus.rd_valid_3 = 1'b0;
    endtask

    task automatic drv(input int b, input logic [3:0] id,
                       input logic [DATA_W-1:0] d);
        case (b)
            0: begin bus.rd_valid_0 = 1'b1; bus.rd_ocid_0 = id; bus.rd_data_0 = d; end
            1: begin bus.rd_valid_1 = 1'b1; bus.rd_ocid_1 = id; bus.rd_data_1 = d; end
            2: begin bus.rd_valid_2 = 1'b1; bus.rd_ocid_2 = id; bus.rd_data_2 = d; end
            default: begin bus.rd_valid_3 = 1'b1; bus.rd_ocid_3 = id; bus.rd_data_3 = d; end
        endcase
    endtask

    task automatic alloc(input logic [TAG_W-1:0] tag,
                         input logic v1, input logic [1:0] b1,
                         input logic v2, input logic [1:0] b2);
        bus.alloc_valid      = 1'b1;
        bus.alloc_tag        = tag;
        bus.alloc_src1_valid = v1;
        bus.alloc_src1_bank  = b1;
        bus.alloc_src2_valid = v2;
        bus.alloc_src2_bank  = b2;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready got %b want 1", bus.alloc_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.err_unexpected !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.err_unexpected); end
        n_cmp++; if (bus.out_tag !== '0) begin n_fail++; $display("FAIL rst_tag got %h want 0", bus.out_tag); end
        n_cmp++; if (bus.out_src1_data !== '0 || bus.out_src2_data !== '0) begin n_fail++; $display("FAIL rst_data got %h/%h want 0", bus.out_src1_data, bus.out_src2_data); end
    endtask

    task automatic test_dual_bank();
        alloc(32'h1111_0001, 1'b1, 2'd1, 1'b1, 2'd3);
        n_cmp++; if (bus.alloc_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL dual_collect got ready=%b busy=%b want 0/1", bus.alloc_ready, bus.busy); end
        drv(1, OC_ID, fill(8'hA5));
        drv(3, OC_ID, fill(8'h3C));
        tick();
        clr_rd();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dual_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_src1_data !== fill(8'hA5)) begin n_fail++; $display("FAIL dual_src1 got %h want A5..", bus.out_src1_data); end
        n_cmp++; if (bus.out_src2_data !== fill(8'h3C)) begin n_fail++; $display("FAIL dual_src2 got %h want 3C..", bus.out_src2_data); end
        n_cmp++; if (bus.out_tag !== 32'h1111_0001) begin n_fail++; $display("FAIL dual_tag got %h want 11110001", bus.out_tag); end
        handshake();
    endtask

    task automatic test_same_bank();
        alloc(32'h2222_0002, 1'b1, 2'd2, 1'b1, 2'd2);
        drv(2, OC_ID, fill(8'h11));
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL same_early_valid got %b want 0", bus.out_valid); end
        drv(2, OC_ID, fill(8'h22));
        tick();
        clr_rd();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL same_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_src1_data !== fill(8'h11)) begin n_fail++; $display("FAIL same_src1 got %h want 11..", bus.out_src1_data); end
        n_cmp++; if (bus.out_src2_data !== fill(8'h22)) begin n_fail++; $display("FAIL same_src2 got %h want 22..", bus.out_src2_data); end
        n_cmp++; if (bus.err_unexpected !== 1'b0) begin n_fail++; $display("FAIL same_err got %b want 0", bus.err_unexpected); end
        handshake();
    endtask

    task automatic test_foreign_ocid();
        alloc(32'h3333_0003, 1'b1, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            drv(0, OC_ID + 4'd1, rnd_data());
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.err_unexpected !== 1'b0) begin n_fail++; $display("FAIL foreign_%0d got valid=%b err=%b want 0/0", i, bus.out_valid, bus.err_unexpected); end
        end
        drv(0, OC_ID, fill(8'h5A));
        tick();
        clr_rd();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src1_data !== fill(8'h5A)) begin n_fail++; $display("FAIL foreign_done got valid=%b src1=%h want 1/5A..", bus.out_valid, bus.out_src1_data); end
        n_cmp++; if (bus.out_src2_data !== '0) begin n_fail++; $display("FAIL foreign_src2 got %h want 0", bus.out_src2_data); end
        handshake();
    endtask

    task automatic test_backpressure();
        alloc(32'h4444_0004, 1'b1, 2'd0, 1'b1, 2'd1);
        drv(0, OC_ID, fill(8'hC3));
        drv(1, OC_ID, fill(8'h96));
        tick();
        clr_rd();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 32'h4444_0004) begin n_fail++; $display("FAIL hold_%0d got valid=%b tag=%h want 1/44440004", i, bus.out_valid, bus.out_tag); end
            n_cmp++; if (bus.out_src1_data !== fill(8'hC3) || bus.out_src2_data !== fill(8'h96)) begin n_fail++; $display("FAIL hold_data_%0d got %h/%h", i, bus.out_src1_data, bus.out_src2_data); end
        end
        handshake();
        n_cmp++; if (bus.alloc_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", bus.alloc_ready, bus.out_valid); end
    endtask

    task automatic test_no_src();
        alloc(32'h5555_0005, 1'b0, 2'd1, 1'b0, 2'd2);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL nosrc_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_src1_data !== '0 || bus.out_src2_data !== '0) begin n_fail++; $display("FAIL nosrc_data got %h/%h want 0", bus.out_src1_data, bus.out_src2_data); end
        handshake();
        drv(1, OC_ID, fill(8'h77));
        tick();
        clr_rd();
        n_cmp++; if (bus.err_unexpected !== 1'b1) begin n_fail++; $display("FAIL idle_err got %b want 1", bus.err_unexpected); end
        tick();
        n_cmp++; if (bus.err_unexpected !== 1'b0) begin n_fail++; $display("FAIL idle_err_pulse got %b want 0", bus.err_unexpected); end
    endtask

    task automatic test_reset_mid();
        alloc(32'h6666_0006, 1'b1, 2'd2, 1'b1, 2'd0);
        drv(0, OC_ID, fill(8'hEE));
        tick();
        clr_rd();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.alloc_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got ready=%b busy=%b valid=%b want 1/0/0", bus.alloc_ready, bus.busy, bus.out_valid); end
        n_cmp++; if (bus.out_src2_data !== '0 || bus.out_tag !== '0) begin n_fail++; $display("FAIL midrst_data got %h tag=%h want 0", bus.out_src2_data, bus.out_tag); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        alloc(32'h6666_0007, 1'b1, 2'd3, 1'b0, 2'd0);
        drv(3, OC_ID, fill(8'h42));
        tick();
        clr_rd();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_src1_data !== fill(8'h42)) begin n_fail++; $display("FAIL midrst_fresh got valid=%b src1=%h", bus.out_valid, bus.out_src1_data); end
        handshake();
    endtask

    task automatic test_random();
        int                q_bank[$];
        int                q_slot[$];
        logic [DATA_W-1:0] exp1, exp2, d;
        logic [TAG_W-1:0]  tag;
        logic              v1, v2, exp_err, hit;
        logic [1:0]        b1, b2;
        logic [3:0]        id;
        int                cyc, idx, hold;
        for (int t = 0; t < 40; t++) begin
            tag = $urandom;
            v1 = 1'($urandom_range(0, 1));
            v2 = 1'($urandom_range(0, 1));
            b1 = 2'($urandom_range(0, 3));
            b2 = 2'($urandom_range(0, 3));
            q_bank.delete();
            q_slot.delete();
            if (v1) begin q_bank.push_back(int'(b1)); q_slot.push_back(1); end
            if (v2) begin q_bank.push_back(int'(b2)); q_slot.push_back(2); end
            exp1 = '0;
            exp2 = '0;
            alloc(tag, v1, b1, v2, b2);
            n_cmp++; if (bus.out_valid !== (q_bank.size() == 0)) begin n_fail++; $display("FAIL rnd%0d_alloc got valid=%b", t, bus.out_valid); end
            cyc = 0;
            while (q_bank.size() != 0 && cyc < 40) begin
                exp_err = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        hit = ($urandom_range(0, 3) != 0);
                        id = hit ? OC_ID : (OC_ID ^ 4'($urandom_range(1, 15)));
                        d = rnd_data();
                        drv(b, id, d);
                        if (hit) begin
                            idx = -1;
                            for (int k = q_bank.size() - 1; k >= 0; k--)
                                if (q_bank[k] == b) idx = k;
                            if (idx < 0) exp_err = 1'b1;
                            else begin
                                if (q_slot[idx] == 1) exp1 = d;
                                else exp2 = d;
                                q_bank.delete(idx);
                                q_slot.delete(idx);
                            end
                        end
                    end
                end
                tick();
                clr_rd();
                cyc++;
                n_cmp++; if (bus.err_unexpected !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", t, bus.err_unexpected, exp_err); end
                n_cmp++; if (bus.out_valid !== (q_bank.size() == 0)) begin n_fail++; $display("FAIL rnd%0d_valid got %b want %b", t, bus.out_valid, q_bank.size() == 0); end
            end
            if (q_bank.size() != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_timeout got %0d pending want 0", t, q_bank.size());
                return;
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                exp_err = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    drv(int'($urandom_range(0, 3)), OC_ID, rnd_data());
                    exp_err = 1'b1;
                end
                tick();
                clr_rd();
                n_cmp++; if (bus.err_unexpected !== exp_err || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_hold got err=%b valid=%b want %b/1", t, bus.err_unexpected, bus.out_valid, exp_err); end
            end
            n_cmp++; if (bus.out_src1_data !== exp1) begin n_fail++; $display("FAIL rnd%0d_src1 got %h want %h", t, bus.out_src1_data, exp1); end
            n_cmp++; if (bus.out_src2_data !== exp2) begin n_fail++; $display("FAIL rnd%0d_src2 got %h want %h", t, bus.out_src2_data, exp2); end
            n_cmp++; if (bus.out_tag !== tag) begin n_fail++; $display("FAIL rnd%0d_tag got %h want %h", t, bus.out_tag, tag); end
            handshake();
            n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready got %b want 1", t, bus.alloc_ready); end
        end
    endtask

    initial begin
        bus.alloc_valid      = 1'b0;
        bus.alloc_tag        = '0;
        bus.alloc_src1_valid = 1'b0;
        bus.alloc_src1_bank  = '0;
        bus.alloc_src2_valid = 1'b0;
        bus.alloc_src2_bank  = '0;
        bus.out_ready        = 1'b0;
        bus.rd_ocid_0 = '0; bus.rd_ocid_1 = '0;
        bus.rd_ocid_2 = '0; bus.rd_ocid_3 = '0;
        bus.rd_data_0 = '0; bus.rd_data_1 = '0;
        bus.rd_data_2 = '0; bus.rd_data_3 = '0;
        clr_rd();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b1;
        tick();
        test_dual_bank();
        test_same_bank();
        test_foreign_ocid();
        test_backpressure();
        test_no_src();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
